// File: rtl/counter_sweep_ctrl_if.sv
// Handshake bundle between the sweep sequencer and its controller plus Counter4 feedback.
// The master side drives start/config/feedback; the slave side (the sequencer) drives controls and status.
interface counter_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic [3:0] step;
    logic [7:0] upper_limit;
    logic [7:0] lower_limit;
    logic [3:0] sweeps;
    logic [7:0] count;
    logic       at_midpoint;

    logic       initialize_count;
    logic       enable_count;
    logic       count_up;
    logic [3:0] n;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] sweeps_done;
    logic [7:0] midpoint_hits;

    modport master (
        output start, abort, step, upper_limit, lower_limit, sweeps, count, at_midpoint,
        input  initialize_count, enable_count, count_up, n, busy, done, error,
               sweeps_done, midpoint_hits
    );

    modport slave (
        input  start, abort, step, upper_limit, lower_limit, sweeps, count, at_midpoint,
        output initialize_count, enable_count, count_up, n, busy, done, error,
               sweeps_done, midpoint_hits
    );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Sequencer that runs Counter4 through a programmed number of up/down sweeps between two limits,
// tracking completed sweeps, midpoint crossings and stalls of the count feedback.
module counter_sweep_ctrl #(
    parameter int INIT_CYCLES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_sweep_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, INIT, UP, DOWN, DONE} state_t;

    localparam logic [3:0] INIT_LAST  = 4'(INIT_CYCLES - 1);
    localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [3:0] step_q;
    logic [3:0] sweeps_q;
    logic [7:0] upper_q;
    logic [7:0] lower_q;
    logic [7:0] count_q;
    logic [3:0] init_cnt;
    logic [7:0] stall_cnt;
    logic       mid_q;

    logic       cfg_ok;
    logic       running;
    logic       mid_rise;
    logic       count_same;
    logic [3:0] sweeps_next;

    assign cfg_ok      = (bus.upper_limit > bus.lower_limit) && (bus.step != 4'd0);
    assign running     = (state == UP) || (state == DOWN);
    assign mid_rise    = running && bus.at_midpoint && !mid_q;
    assign count_same  = (bus.count == count_q);
    assign sweeps_next = bus.sweeps_done + 4'd1;

    // NOTE: every state bit lives in this one clocked block and is written with <= only, so the
    // order of the statements below never changes what a neighbouring assignment reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            step_q               <= '0;
            sweeps_q             <= '0;
            upper_q              <= '0;
            lower_q              <= '0;
            count_q              <= '0;
            init_cnt             <= '0;
            stall_cnt            <= '0;
            mid_q                <= 1'b0;
            bus.initialize_count <= 1'b0;
            bus.enable_count     <= 1'b0;
            bus.count_up         <= 1'b0;
            bus.n                <= '0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
            bus.error            <= 1'b0;
            bus.sweeps_done      <= '0;
            bus.midpoint_hits    <= '0;
        end else begin
            count_q  <= bus.count;
            mid_q    <= bus.at_midpoint;
            bus.done <= 1'b0;

            if (mid_rise && bus.midpoint_hits != 8'hFF)
                bus.midpoint_hits <= bus.midpoint_hits + 8'd1;

            if (bus.abort) begin
                state                <= IDLE;
                stall_cnt            <= '0;
                bus.initialize_count <= 1'b0;
                bus.enable_count     <= 1'b0;
                bus.count_up         <= 1'b0;
                bus.busy             <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && cfg_ok) begin
                            step_q               <= bus.step;
                            sweeps_q             <= bus.sweeps;
                            upper_q              <= bus.upper_limit;
                            lower_q              <= bus.lower_limit;
                            init_cnt             <= '0;
                            bus.sweeps_done      <= '0;
                            bus.midpoint_hits    <= '0;
                            bus.error            <= 1'b0;
                            bus.initialize_count <= 1'b1;
                            bus.busy             <= 1'b1;
                            state                <= INIT;
                        end else if (bus.start) begin
                            bus.error <= 1'b1;
                        end
                    end
                    INIT: begin
                        if (init_cnt == INIT_LAST) begin
                            bus.initialize_count <= 1'b0;
                            bus.enable_count     <= 1'b1;
                            bus.count_up         <= 1'b1;
                            bus.n                <= step_q;
                            stall_cnt            <= '0;
                            state                <= UP;
                        end else begin
                            init_cnt <= init_cnt + 4'd1;
                        end
                    end
                    UP, DOWN: begin
                        if (count_same && stall_cnt == STALL_LAST) begin
                            bus.error        <= 1'b1;
                            bus.enable_count <= 1'b0;
                            bus.count_up     <= 1'b0;
                            bus.busy         <= 1'b0;
                            stall_cnt        <= '0;
                            state            <= IDLE;
                        end else begin
                            stall_cnt <= count_same ? stall_cnt + 8'd1 : 8'd0;
                            // Turn points use the feedback registered last cycle; overshoot is expected.
                            if (state == UP && count_q >= upper_q) begin
                                bus.count_up <= 1'b0;
                                state        <= DOWN;
                            end else if (state == DOWN && count_q <= lower_q) begin
                                bus.sweeps_done <= sweeps_next;
                                if (sweeps_q != 4'd0 && sweeps_next == sweeps_q) begin
                                    bus.enable_count <= 1'b0;
                                    bus.busy         <= 1'b0;
                                    bus.done         <= 1'b1;
                                    state            <= DONE;
                                end else begin
                                    bus.count_up <= 1'b1;
                                    state        <= UP;
                                end
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl driving a small saturating Counter4 model as feedback.
module tb_counter_sweep_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    counter_sweep_ctrl_if ifc ();

    counter_sweep_ctrl #(.INIT_CYCLES(2), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int checks   = 0;
    int failures = 0;

    // Counter4 stand-in: initialize clears, enable steps by n, saturating at 0 and 255.
    logic [7:0] model_count;
    logic       override  = 1'b0;
    logic [7:0] force_val = 8'd0;
    assign ifc.count = override ? force_val : model_count;

    always @(posedge clk) begin
        if (rst || ifc.initialize_count)
            model_count <= 8'd0;
        else if (ifc.enable_count) begin
            if (ifc.count_up)
                model_count <= (9'(model_count) + 9'(ifc.n) > 9'd255) ? 8'd255 : model_count + 8'(ifc.n);
            else
                model_count <= (model_count < 8'(ifc.n)) ? 8'd0 : model_count - 8'(ifc.n);
        end
    end

    int   done_count = 0;
    int   up_falls   = 0;
    logic prev_up    = 1'b0;
    always @(posedge clk) begin
        if (ifc.done === 1'b1) done_count <= done_count + 1;
        if (prev_up === 1'b1 && ifc.count_up === 1'b0) up_falls <= up_falls + 1;
        prev_up <= ifc.count_up;
    end

    task automatic drive_start(input logic [3:0] step, input logic [7:0] upper,
                               input logic [7:0] lower, input logic [3:0] sweeps);
        @(negedge clk);
        ifc.step        = step;
        ifc.upper_limit = upper;
        ifc.lower_limit = lower;
        ifc.sweeps      = sweeps;
        ifc.start       = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic wait_enable(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = (ifc.enable_count === 1'b1);
        end
    endtask

    task automatic test_reset();
        ifc.start = 0; ifc.abort = 0; ifc.step = 0; ifc.upper_limit = 0;
        ifc.lower_limit = 0; ifc.sweeps = 0; ifc.at_midpoint = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ifc.initialize_count, ifc.enable_count, ifc.count_up, ifc.n, ifc.busy, ifc.done,
             ifc.error, ifc.sweeps_done, ifc.midpoint_hits} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs: got init=%b en=%b up=%b n=%h busy=%b done=%b err=%b sw=%h mh=%h, expected all 0",
                     ifc.initialize_count, ifc.enable_count, ifc.count_up, ifc.n, ifc.busy,
                     ifc.done, ifc.error, ifc.sweeps_done, ifc.midpoint_hits);
        end
    endtask

    task automatic test_invalid_config();
        drive_start(4'd1, 8'd10, 8'd10, 4'd1);
        checks++;
        if (ifc.error !== 1'b1) begin failures++; $display("FAIL invalid_error: got %b expected 1", ifc.error); end
        checks++;
        if (ifc.busy !== 1'b0) begin failures++; $display("FAIL invalid_busy: got %b expected 0", ifc.busy); end
        checks++;
        if ({ifc.initialize_count, ifc.enable_count, ifc.count_up, ifc.n} !== 7'd0) begin
            failures++;
            $display("FAIL invalid_ctrl: got %h expected 0", {ifc.initialize_count, ifc.enable_count, ifc.count_up, ifc.n});
        end
        @(negedge clk);
        checks++;
        if (ifc.busy !== 1'b0 || ifc.initialize_count !== 1'b0) begin
            failures++; $display("FAIL invalid_stays_idle: got busy=%b init=%b expected 0 0", ifc.busy, ifc.initialize_count);
        end
    endtask

    task automatic test_sweep();
        bit ok;
        done_count = 0; up_falls = 0;
        drive_start(4'd3, 8'd30, 8'd3, 4'd2);
        checks++;
        if (ifc.busy !== 1'b1 || ifc.initialize_count !== 1'b1 || ifc.enable_count !== 1'b0) begin
            failures++; $display("FAIL sweep_start: got busy=%b init=%b en=%b expected 1 1 0", ifc.busy, ifc.initialize_count, ifc.enable_count);
        end
        checks++;
        if (ifc.error !== 1'b0) begin failures++; $display("FAIL sweep_error_cleared: got %b expected 0", ifc.error); end
        @(negedge clk);
        checks++;
        if (ifc.initialize_count !== 1'b1 || ifc.enable_count !== 1'b0) begin
            failures++; $display("FAIL sweep_init_cycle2: got init=%b en=%b expected 1 0", ifc.initialize_count, ifc.enable_count);
        end
        @(negedge clk);
        checks++;
        if ({ifc.initialize_count, ifc.enable_count, ifc.count_up, ifc.n} !== {3'b011, 4'd3}) begin
            failures++; $display("FAIL sweep_enter_up: got %h expected %h", {ifc.initialize_count, ifc.enable_count, ifc.count_up, ifc.n}, {3'b011, 4'd3});
        end
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = (ifc.done === 1'b1);
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL sweep_done_timeout: got no done within 400 cycles, expected a done pulse"); end
        checks++;
        if (ifc.sweeps_done !== 4'd2) begin failures++; $display("FAIL sweep_count: got %0d expected 2", ifc.sweeps_done); end
        checks++;
        if ({ifc.busy, ifc.enable_count, ifc.count_up, ifc.n} !== {3'b000, 4'd3}) begin
            failures++; $display("FAIL sweep_done_outputs: got %h expected %h", {ifc.busy, ifc.enable_count, ifc.count_up, ifc.n}, {3'b000, 4'd3});
        end
        @(negedge clk);
        checks++;
        if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
            failures++; $display("FAIL sweep_after_done: got done=%b busy=%b expected 0 0", ifc.done, ifc.busy);
        end
        checks++;
        if (done_count !== 1) begin failures++; $display("FAIL sweep_done_pulses: got %0d expected 1", done_count); end
        checks++;
        if (up_falls !== 2) begin failures++; $display("FAIL sweep_turns: got %0d expected 2", up_falls); end
    endtask

    task automatic test_abort();
        bit ok;
        done_count = 0;
        drive_start(4'd1, 8'd8, 8'd0, 4'd0);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = (ifc.sweeps_done === 4'd3);
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL abort_wait_sweeps: got %0d sweeps after 400 cycles, expected 3", ifc.sweeps_done); end
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
        checks++;
        if ({ifc.busy, ifc.initialize_count, ifc.enable_count, ifc.count_up} !== 4'd0) begin
            failures++; $display("FAIL abort_ctrl: got %b expected 0000", {ifc.busy, ifc.initialize_count, ifc.enable_count, ifc.count_up});
        end
        checks++;
        if (ifc.sweeps_done !== 4'd3) begin failures++; $display("FAIL abort_sweeps_hold: got %0d expected 3", ifc.sweeps_done); end
        @(negedge clk);
        checks++;
        if (ifc.busy !== 1'b0 || done_count !== 0) begin
            failures++; $display("FAIL abort_no_done: got busy=%b done_pulses=%0d expected 0 0", ifc.busy, done_count);
        end
        // Reset in the middle of a run.
        drive_start(4'd1, 8'd8, 8'd0, 4'd0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ifc.initialize_count, ifc.enable_count, ifc.count_up, ifc.n, ifc.busy, ifc.done,
             ifc.error, ifc.sweeps_done, ifc.midpoint_hits} !== 22'd0 || done_count !== 0) begin
            failures++; $display("FAIL reset_midrun: got busy=%b en=%b n=%h done_pulses=%0d expected all 0",
                                 ifc.busy, ifc.enable_count, ifc.n, done_count);
        end
    endtask

    task automatic test_stall();
        bit ok;
        done_count = 0;
        drive_start(4'd1, 8'd200, 8'd0, 4'd1);
        wait_enable(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_enter_up: got enable=%b expected 1", ifc.enable_count); end
        repeat (3) @(negedge clk);
        force_val = 8'd99;
        override  = 1'b1;
        @(posedge clk);
        repeat (63) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ifc.error !== 1'b0 || ifc.busy !== 1'b1) begin
            failures++; $display("FAIL stall_early: got err=%b busy=%b expected 0 1 after 63 cycles", ifc.error, ifc.busy);
        end
        @(negedge clk);
        checks++;
        if (ifc.error !== 1'b1) begin failures++; $display("FAIL stall_error: got %b expected 1 after 64 cycles", ifc.error); end
        checks++;
        if ({ifc.busy, ifc.enable_count, ifc.count_up, ifc.initialize_count} !== 4'd0 || done_count !== 0) begin
            failures++; $display("FAIL stall_idle: got ctrl=%b done_pulses=%0d expected 0000 0",
                                 {ifc.busy, ifc.enable_count, ifc.count_up, ifc.initialize_count}, done_count);
        end
        override = 1'b0;
    endtask

    task automatic test_midpoint();
        bit ok;
        drive_start(4'd1, 8'd200, 8'd0, 4'd0);
        checks++;
        if (ifc.error !== 1'b0) begin failures++; $display("FAIL mid_error_cleared: got %b expected 0", ifc.error); end
        wait_enable(ok);
        for (int i = 0; i < 5; i++) begin
            ifc.at_midpoint = 1'b1;
            repeat (2) @(negedge clk);
            ifc.at_midpoint = 1'b0;
            repeat (2) @(negedge clk);
        end
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ifc.at_midpoint = 1'b1;
            repeat (2) @(negedge clk);
            ifc.at_midpoint = 1'b0;
            repeat (2) @(negedge clk);
        end
        checks++;
        if (ifc.midpoint_hits !== 8'd5) begin failures++; $display("FAIL mid_hits: got %0d expected 5", ifc.midpoint_hits); end
        drive_start(4'd1, 8'd250, 8'd0, 4'd0);
        checks++;
        if (ifc.midpoint_hits !== 8'd0) begin failures++; $display("FAIL mid_hits_cleared: got %0d expected 0", ifc.midpoint_hits); end
        wait_enable(ok);
        for (int i = 0; i < 300; i++) begin
            ifc.at_midpoint = 1'b1;
            @(negedge clk);
            ifc.at_midpoint = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (ifc.midpoint_hits !== 8'd255 || ifc.busy !== 1'b1) begin
            failures++; $display("FAIL mid_saturate: got hits=%0d busy=%b expected 255 1", ifc.midpoint_hits, ifc.busy);
        end
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        drive_start(4'd2, 8'd20, 8'd0, 4'd1);
        wait_enable(ok);
        repeat (2) @(negedge clk);
        ifc.step = 4'd5; ifc.upper_limit = 8'd100; ifc.lower_limit = 8'd50; ifc.sweeps = 4'd3;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        checks++;
        if (ifc.n !== 4'd2 || ifc.busy !== 1'b1 || ifc.initialize_count !== 1'b0) begin
            failures++; $display("FAIL b2b_ignored: got n=%0d busy=%b init=%b expected 2 1 0", ifc.n, ifc.busy, ifc.initialize_count);
        end
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (ifc.done === 1'b1);
        end
        checks++;
        if (!ok || ifc.sweeps_done !== 4'd1) begin
            failures++; $display("FAIL b2b_config_kept: got done_seen=%b sweeps=%0d expected 1 1", ok, ifc.sweeps_done);
        end
        @(negedge clk);
        ifc.step = 4'd1; ifc.upper_limit = 8'd20; ifc.lower_limit = 8'd0; ifc.sweeps = 4'd1;
        ifc.start = 1'b1;
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        checks++;
        if (ifc.busy !== 1'b0 || ifc.initialize_count !== 1'b0) begin
            failures++; $display("FAIL start_abort_idle: got busy=%b init=%b expected 0 0", ifc.busy, ifc.initialize_count);
        end
        @(negedge clk);
        checks++;
        if (ifc.busy !== 1'b0 || ifc.initialize_count !== 1'b0 || ifc.error !== 1'b0) begin
            failures++; $display("FAIL start_abort_no_init: got busy=%b init=%b err=%b expected 0 0 0", ifc.busy, ifc.initialize_count, ifc.error);
        end
    endtask

    initial begin
        test_reset();
        test_invalid_config();
        test_sweep();
        test_abort();
        test_stall();
        test_midpoint();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion by 500000 time units, expected finish");
        $fatal(1, "bench timed out");
    end
endmodule
